// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
// Holds the reset vector, the default queue sizing and the buffer entry layout.
package inst_prefetch_queue_pkg;

  localparam logic [31:0] VEC_RESET        = 32'hBFC0_0000;
  localparam int unsigned PREFETCH_DEPTH   = 4;
  localparam int unsigned PREFETCH_MAX_OUT = 4;
  localparam logic [31:0] FETCH_STRIDE     = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return pc + FETCH_STRIDE;
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_checker.sv
// Protocol and bookkeeping assertions for the instruction prefetch queue.
module inst_prefetch_queue_checker #(
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned MAX_OUT = 4
) (
  input logic             clk,
  input logic             reset,
  input logic             inst_data_ok,
  input logic             accept,
  input logic             tag_pop,
  input logic             buf_push,
  input logic             buf_pop,
  input logic             tag_empty,
  input logic             tag_full,
  input logic             buf_full,
  input logic [TAG_W-1:0] tag_count,
  input logic [CNT_W-1:0] live_cnt,
  input logic [CNT_W-1:0] drop_cnt
);

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    inst_data_ok |-> (live_cnt != {CNT_W{1'b0}} || drop_cnt != {CNT_W{1'b0}}));

  a_tag_tracks_live: assert property (@(posedge clk) disable iff (reset)
    32'(tag_count) == 32'(live_cnt));

  a_tag_no_overflow: assert property (@(posedge clk) disable iff (reset)
    accept |-> !tag_full);

  a_tag_no_underflow: assert property (@(posedge clk) disable iff (reset)
    tag_pop |-> !tag_empty);

  a_buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
    buf_push |-> (!buf_full || buf_pop));

  a_drop_bounded: assert property (@(posedge clk) disable iff (reset)
    32'(drop_cnt) <= MAX_OUT);

endmodule

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head.
// clear empties the queue in one cycle and takes priority over push/pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Qualify requests: a push into a full queue is only legal alongside a pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == {CW{1'b0}});
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      cnt    <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: keeps several fetches in flight on the inst bus and
// buffers returned instructions with their PCs; redirects drop stale responses by count.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = PREFETCH_DEPTH,
  parameter int unsigned MAX_OUT  = PREFETCH_MAX_OUT,
  parameter logic [31:0] RESET_PC = VEC_RESET,
  parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             hold,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic [31:0]      inst_rdata,
  input  logic             inst_data_ok,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready,
  output logic [CNT_W-1:0] inflight
);

  localparam int unsigned TAG_W = $clog2(MAX_OUT) + 1;

  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] live_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] live_next;
  logic [CNT_W-1:0] drop_next;
  logic [CNT_W:0]   occ_sum;
  logic [CNT_W:0]   out_sum;
  logic             accept;
  logic             resp_live;
  logic             resp_drop;
  logic             buf_push;
  logic             buf_pop;
  logic [31:0]      tag_head;
  logic             tag_empty;
  logic             tag_full;
  logic [TAG_W-1:0] tag_count;
  fetch_entry_t     buf_head;
  fetch_entry_t     buf_in;
  logic             buf_empty;
  logic             buf_full;
  logic [CNT_W-1:0] buf_count;

  // Credit check: a buffer slot is reserved at address accept, so the buffer cannot overflow.
  always_comb begin
    occ_sum = {1'b0, buf_count} + {1'b0, live_cnt};
    out_sum = {1'b0, live_cnt} + {1'b0, drop_cnt};
    if (!reset && !redirect && !hold
        && (occ_sum < (CNT_W + 1)'(DEPTH)) && (out_sum < (CNT_W + 1)'(MAX_OUT))) begin
      inst_req = 1'b1;
    end else begin
      inst_req = 1'b0;
    end
  end

  assign inst_addr = fetch_pc;
  assign accept    = inst_req && inst_addr_ok;
  assign resp_drop = inst_data_ok && (drop_cnt != {CNT_W{1'b0}});
  assign resp_live = inst_data_ok && (drop_cnt == {CNT_W{1'b0}}) && (live_cnt != {CNT_W{1'b0}});
  assign buf_push  = resp_live && !redirect;
  assign buf_pop   = out_valid && out_ready && !redirect;
  assign buf_in    = '{pc: tag_head, inst: inst_rdata};
  assign inflight  = live_cnt + drop_cnt;

  // Outstanding-count bookkeeping; on redirect every live request becomes a drop.
  always_comb begin
    if (redirect) begin
      live_next = {CNT_W{1'b0}};
      drop_next = drop_cnt + live_cnt
                - CNT_W'(inst_data_ok && (out_sum != {(CNT_W + 1){1'b0}}));
    end else begin
      live_next = live_cnt + CNT_W'(accept) - CNT_W'(resp_live);
      drop_next = drop_cnt - CNT_W'(resp_drop);
    end
  end

  // Fetch PC and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      live_cnt <= {CNT_W{1'b0}};
      drop_cnt <= {CNT_W{1'b0}};
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (accept) begin
        fetch_pc <= next_fetch_pc(fetch_pc);
      end
      live_cnt <= live_next;
      drop_cnt <= drop_next;
    end
  end

  // Head presentation; PC and instruction read as zero while the buffer is empty.
  always_comb begin
    out_valid = !buf_empty;
    if (!buf_empty) begin
      out_pc   = buf_head.pc;
      out_inst = buf_head.inst;
    end else begin
      out_pc   = 32'h0000_0000;
      out_inst = 32'h0000_0000;
    end
  end

  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (resp_live),
    .clear     (redirect),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .clear     (redirect),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  inst_prefetch_queue_checker #(.CNT_W(CNT_W), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)) u_checker (
    .clk          (clk),
    .reset        (reset),
    .inst_data_ok (inst_data_ok),
    .accept       (accept),
    .tag_pop      (resp_live),
    .buf_push     (buf_push),
    .buf_pop      (buf_pop),
    .tag_empty    (tag_empty),
    .tag_full     (tag_full),
    .buf_full     (buf_full),
    .tag_count    (tag_count),
    .live_cnt     (live_cnt),
    .drop_cnt     (drop_cnt)
  );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: an in-order bus model with programmable
// response latency, and hand-computed PC/instruction expectations per scenario.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [2:0]  inflight;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int max_inflight = 0;
  logic        last_req;
  logic        last_valid;
  logic [31:0] last_addr;
  int          last_inflight;
  logic [31:0] pend_addr[$];
  int          pend_t[$];
  logic [31:0] acc_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  always #5 clk = ~clk;

  inst_prefetch_queue #(.DEPTH(4), .MAX_OUT(4), .RESET_PC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .hold         (hold),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_ready    (out_ready),
    .inflight     (inflight)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_DEAD;
  endfunction

  // One bus cycle: drive inputs at negedge, sample, then advance past posedge.
  task automatic cyc(input logic rd, input logic [31:0] rpc, input logic hl,
                     input logic aok, input logic ordy, input int lat);
    logic resp;
    @(negedge clk);
    redirect = rd; redirect_pc = rpc; hold = hl; inst_addr_ok = aok; out_ready = ordy;
    resp = (pend_addr.size() > 0) && (cycle >= pend_t[0] + lat);
    inst_data_ok = resp;
    inst_rdata = resp ? ~pend_addr[0] : 32'h0000_0000;
    #1;
    last_req = inst_req; last_valid = out_valid; last_addr = inst_addr;
    last_inflight = int'(inflight);
    if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
    if (out_valid && out_ready && !redirect) begin
      got_pc.push_back(out_pc);
      got_inst.push_back(out_inst);
    end
    if (resp) begin
      void'(pend_addr.pop_front());
      void'(pend_t.pop_front());
    end
    if (inst_req && inst_addr_ok) begin
      pend_addr.push_back(inst_addr);
      pend_t.push_back(cycle);
      acc_log.push_back(inst_addr);
    end
    @(posedge clk);
    cycle++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; hold = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", {31'd0, inst_req}, 32'd0);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_pc", out_pc, 32'h0);
    check_eq("rst_inst", out_inst, 32'h0);
    check_eq("rst_inflight", {29'd0, inflight}, 32'd0);
    pend_addr.delete(); pend_t.delete(); acc_log.delete();
    got_pc.delete(); got_inst.delete();
    cycle = 0; max_inflight = 0;
    reset = 1'b0;
    #1;
    check_eq("rst_req_after", {31'd0, inst_req}, 32'd1);
    check_eq("rst_addr", inst_addr, 32'hBFC0_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming with a single-cycle bus.
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("stream_count", got_pc.size(), 32'd10);
    for (int i = 0; i < 8; i++) begin
      check_eq("stream_pc", pick(got_pc, i), 32'hBFC0_0000 + 32'(4 * i));
      check_eq("stream_inst", pick(got_inst, i), ~(32'hBFC0_0000 + 32'(4 * i)));
    end
    check_eq("stream_inflight_le1", {31'd0, max_inflight <= 1}, 32'd1);

    // Backpressure: exactly DEPTH accepts, then resume at BFC00010.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);
    check_eq("bp_accepts", acc_log.size(), 32'd4);
    check_eq("bp_req_low", {31'd0, last_req}, 32'd0);
    check_eq("bp_valid", {31'd0, last_valid}, 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 4; i++) check_eq("bp_pc", pick(got_pc, i), 32'hBFC0_0000 + 32'(4 * i));
    check_eq("bp_inst0", pick(got_inst, 0), 32'h403F_FFFF);
    check_eq("bp_resume", pick(acc_log, 4), 32'hBFC0_0010);

    // Slow bus: six-cycle response latency saturates the outstanding limit.
    do_reset();
    for (int i = 0; i < 40; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 6);
    check_eq("slow_max_inflight", max_inflight, 32'd4);
    check_eq("slow_count_ge8", {31'd0, got_pc.size() >= 8}, 32'd1);
    for (int i = 0; i < got_pc.size(); i++) begin
      check_eq("slow_pc", got_pc[i], 32'hBFC0_0000 + 32'(4 * i));
      check_eq("slow_inst", got_inst[i], ~(32'hBFC0_0000 + 32'(4 * i)));
    end

    // Redirect with three requests in flight.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 20);
    cyc(1'b1, 32'h8000_0180, 1'b0, 1'b1, 1'b1, 20);
    check_eq("rd3_req_low", {31'd0, last_req}, 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("rd3_inflight", last_inflight, 32'd3);
    check_eq("rd3_addr", last_addr, 32'h8000_0180);
    check_eq("rd3_valid", {31'd0, last_valid}, 32'd0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("rd3_pc0", pick(got_pc, 0), 32'h8000_0180);
    check_eq("rd3_inst0", pick(got_inst, 0), 32'h7FFF_FE7F);
    check_eq("rd3_pc1", pick(got_pc, 1), 32'h8000_0184);
    check_eq("rd3_pc2", pick(got_pc, 2), 32'h8000_0188);

    // Redirect coinciding with a response and a pop, two live requests.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2);
    cyc(1'b1, 32'h8000_0200, 1'b0, 1'b1, 1'b1, 2);
    check_eq("rdc_live_before", last_inflight, 32'd2);
    check_eq("rdc_valid_before", {31'd0, last_valid}, 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("rdc_inflight", last_inflight, 32'd1);
    check_eq("rdc_valid_after", {31'd0, last_valid}, 32'd0);
    check_eq("rdc_no_stale", got_pc.size(), 32'd0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("rdc_pc0", pick(got_pc, 0), 32'h8000_0200);
    check_eq("rdc_inst0", pick(got_inst, 0), 32'h7FFF_FDFF);

    // hold for five cycles with two requests in flight.
    do_reset();
    for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 5);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 5);
    check_eq("hold_req_low", {31'd0, last_req}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 5);
    check_eq("hold_accepts", acc_log.size(), 32'd2);
    check_eq("hold_popped", got_pc.size(), 32'd1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("hold_resume", pick(acc_log, 2), 32'hBFC0_0008);
    for (int i = 0; i < 3; i++) check_eq("hold_pc", pick(got_pc, i), 32'hBFC0_0000 + 32'(4 * i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
